pwm_peripheral: RTL

PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

---
 rtl/pwm_peripheral.sv | 65 ++++++
 1 files changed

// File: rtl/pwm_peripheral.sv
// Free-running PWM generator behind the SPI register bank: one shared duty phase,
// with per-bit output enables and PWM-mode selects applied on a registered output stage.
module pwm_peripheral #(
    parameter int CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] DIV_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] prescaler;
    logic [7:0]    pwm_count;
    logic [7:0]    duty_shadow;
    logic          started;
    logic          tick;
    logic          boundary;
    logic          pwm_level;
    logic [15:0]   en_out;
    logic [15:0]   en_pwm;
    logic [15:0]   out_next;

    assign tick     = (prescaler == DIV_MAX);
    assign boundary = tick && (pwm_count == 8'hFF);
    assign en_out   = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Duty 0xFF is forced high so the compare never produces a low slot at count 255.
    always_comb begin
        pwm_level = (duty_shadow == 8'hFF) || (pwm_count < duty_shadow);
        out_next  = en_out & (~en_pwm | {16{pwm_level}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler    <= '0;
            pwm_count    <= 8'd0;
            duty_shadow  <= 8'd0;
            started      <= 1'b0;
            period_start <= 1'b0;
            out          <= 16'h0000;
        end else begin
            prescaler    <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                pwm_count <= pwm_count + 8'd1;
            end
            started      <= 1'b1;
            // A new duty only lands when a period begins, or on the very first clock after reset.
            if (boundary || !started) begin
                duty_shadow <= pwm_duty_cycle;
            end
            period_start <= boundary;
            out          <= out_next;
        end
    end

endmodule
